// File: rtl/sobel_stream_core.sv
// Streaming 3x3 Sobel core: two on-chip line buffers feed a sliding window, and
// one registered result (Gx, Gy, |Gx|+|Gy| or thresholded) is emitted per interior pixel.
module sobel_stream_core #(
  parameter int IMG_W   = 640,
  parameter int IMG_H   = 480,
  parameter int PIX_W   = 8,
  parameter int COORD_W = 11
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [PIX_W-1:0]   in_pixel,
  input  logic [1:0]         mode,
  input  logic [PIX_W+2:0]   thresh,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [PIX_W+3:0]   out_pixel,
  output logic [COORD_W-1:0] out_x,
  output logic [COORD_W-1:0] out_y,
  output logic               out_last
);

  localparam int OUT_W = PIX_W + 4;
  localparam int XA_W  = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam logic [COORD_W-1:0] X_LAST = COORD_W'(IMG_W - 1);
  localparam logic [COORD_W-1:0] Y_LAST = COORD_W'(IMG_H - 1);
  localparam logic [COORD_W-1:0] C_ONE  = COORD_W'(1);
  localparam logic [COORD_W-1:0] C_TWO  = COORD_W'(2);

  typedef logic signed [OUT_W-1:0] sres_t;

  logic [COORD_W-1:0] r_in_x;
  logic [COORD_W-1:0] r_in_y;
  logic [1:0]         r_mode;
  logic [PIX_W+2:0]   r_thresh;

  logic               r_out_valid;
  logic [OUT_W-1:0]   r_out_pixel;
  logic [COORD_W-1:0] r_out_x;
  logic [COORD_W-1:0] r_out_y;
  logic               r_out_last;

  logic [PIX_W-1:0]   r_lb0 [IMG_W];
  logic [PIX_W-1:0]   r_lb1 [IMG_W];
  logic [PIX_W-1:0]   r_win_c0 [3];
  logic [PIX_W-1:0]   r_win_c1 [3];

  logic               w_accept;
  logic               w_qual;
  logic               w_frame_start;
  logic               w_last;
  logic [XA_W-1:0]    w_addr;
  logic [PIX_W-1:0]   w_col [3];
  sres_t              w_ext [3][3];
  sres_t              w_gx;
  sres_t              w_gy;
  sres_t              w_abs_gx;
  sres_t              w_abs_gy;
  logic [OUT_W-1:0]   w_mag;
  logic               w_hit;
  logic [OUT_W-1:0]   w_result;

  assign in_ready      = !r_out_valid || out_ready;
  assign w_accept      = in_valid && in_ready;
  assign w_addr        = r_in_x[XA_W-1:0];
  assign w_qual        = (r_in_x >= C_TWO) && (r_in_y >= C_TWO);
  assign w_frame_start = (r_in_x == '0) && (r_in_y == '0);
  assign w_last        = (r_in_x == X_LAST) && (r_in_y == Y_LAST);

  // Line buffers are read combinationally so the new column joins the window in the accept cycle.
  assign w_col[0] = r_lb0[w_addr];
  assign w_col[1] = r_lb1[w_addr];
  assign w_col[2] = in_pixel;

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_row
      assign w_ext[gi][0] = $signed({4'b0000, r_win_c0[gi]});
      assign w_ext[gi][1] = $signed({4'b0000, r_win_c1[gi]});
      assign w_ext[gi][2] = $signed({4'b0000, w_col[gi]});
    end
  endgenerate

  assign w_gx = (w_ext[0][2] + w_ext[1][2] + w_ext[1][2] + w_ext[2][2])
              - (w_ext[0][0] + w_ext[1][0] + w_ext[1][0] + w_ext[2][0]);
  assign w_gy = (w_ext[2][0] + w_ext[2][1] + w_ext[2][1] + w_ext[2][2])
              - (w_ext[0][0] + w_ext[0][1] + w_ext[0][1] + w_ext[0][2]);

  assign w_abs_gx = w_gx[OUT_W-1] ? -w_gx : w_gx;
  assign w_abs_gy = w_gy[OUT_W-1] ? -w_gy : w_gy;
  assign w_mag    = w_abs_gx + w_abs_gy;
  assign w_hit    = w_mag >= {1'b0, r_thresh};

  always_comb begin
    w_result = '0;
    case (r_mode)
      2'b00:   w_result = w_gx;
      2'b01:   w_result = w_gy;
      2'b10:   w_result = w_mag;
      default: w_result = w_hit ? {4'b0000, {PIX_W{1'b1}}} : '0;
    endcase
  end

  // Storage that is always written before it is read within a frame carries no reset.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_lb0[w_addr] <= r_lb1[w_addr];
      r_lb1[w_addr] <= in_pixel;
      for (int r = 0; r < 3; r++) begin
        r_win_c0[r] <= r_win_c1[r];
        r_win_c1[r] <= w_col[r];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_in_x      <= '0;
      r_in_y      <= '0;
      r_mode      <= 2'b00;
      r_thresh    <= '0;
      r_out_valid <= 1'b0;
      r_out_pixel <= '0;
      r_out_x     <= '0;
      r_out_y     <= '0;
      r_out_last  <= 1'b0;
    end else begin
      if (w_accept) begin
        if (r_in_x == X_LAST) begin
          r_in_x <= '0;
          r_in_y <= (r_in_y == Y_LAST) ? '0 : r_in_y + C_ONE;
        end else begin
          r_in_x <= r_in_x + C_ONE;
        end
        if (w_frame_start) begin
          r_mode   <= mode;
          r_thresh <= thresh;
        end
        // An accept implies the previous result is gone, so a border pixel leaves the register empty.
        r_out_valid <= w_qual;
        if (w_qual) begin
          r_out_pixel <= w_result;
          r_out_x     <= r_in_x - C_ONE;
          r_out_y     <= r_in_y - C_ONE;
          r_out_last  <= w_last;
        end
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_pixel = r_out_pixel;
  assign out_x     = r_out_x;
  assign out_y     = r_out_y;
  assign out_last  = r_out_last;

endmodule

// File: tb/tb_sobel_stream_core.sv
// Directed bench for sobel_stream_core on an 8x6 image: table of frames with
// hand-computed spot values plus a convolution reference, then stall, mode-switch and reset sequences.
module tb_sobel_stream_core;

  localparam int W  = 8;
  localparam int H  = 6;
  localparam int PW = 8;
  localparam int CW = 11;
  localparam int OW = PW + 4;
  localparam int NRES = (W - 2) * (H - 2);

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [PW-1:0] in_pixel;
  logic [1:0]    mode;
  logic [PW+2:0] thresh;
  logic          out_valid;
  logic          out_ready;
  logic [OW-1:0] out_pixel;
  logic [CW-1:0] out_x;
  logic [CW-1:0] out_y;
  logic          out_last;

  always #5 clk = ~clk;

  sobel_stream_core #(.IMG_W(W), .IMG_H(H), .PIX_W(PW), .COORD_W(CW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_pixel(in_pixel),
    .mode(mode), .thresh(thresh),
    .out_valid(out_valid), .out_ready(out_ready), .out_pixel(out_pixel),
    .out_x(out_x), .out_y(out_y), .out_last(out_last)
  );

  typedef struct {int pix; int x; int y; int last;} res_t;
  typedef struct {int pat; int md; int thr; int cx; int cy; int exp;} vec_t;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   ready_mode = 0;
  int   img [H][W];
  res_t got [$];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // out_ready driver: 0 = always ready, 1 = ~30% low, 2 = never ready
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ($urandom_range(0, 9) >= 3);
        default: out_ready = 1'b0;
      endcase
    end
  end

  // Result collector and hold-stability checker.
  initial begin
    res_t cur;
    res_t held;
    bit   held_v = 0;
    forever begin
      @(negedge clk);
      cur.pix  = int'($signed(out_pixel));
      cur.x    = int'(out_x);
      cur.y    = int'(out_y);
      cur.last = int'(out_last);
      if (rst) begin
        held_v = 0;
      end else begin
        if (held_v) begin
          chk("hold_valid", int'(out_valid), 1);
          chk("hold_data", cur.pix * 1000000 + cur.x * 10000 + cur.y * 10 + cur.last,
              held.pix * 1000000 + held.x * 10000 + held.y * 10 + held.last);
        end
        if (out_valid && out_ready) got.push_back(cur);
        held_v = out_valid && !out_ready;
        held   = cur;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  function automatic int sobel_ref(input int cx, input int cy, input int md, input int thr);
    int kx [3][3];
    int gx, gy, v, mag;
    kx = '{'{-1, 0, 1}, '{-2, 0, 2}, '{-1, 0, 1}};
    gx = 0;
    gy = 0;
    for (int dr = 0; dr < 3; dr++)
      for (int dc = 0; dc < 3; dc++) begin
        v  = img[cy - 1 + dr][cx - 1 + dc];
        gx += kx[dr][dc] * v;
        gy += kx[dc][dr] * v;
      end
    mag = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
    case (md)
      0:       return gx;
      1:       return gy;
      2:       return mag;
      default: return (mag >= thr) ? 255 : 0;
    endcase
  endfunction

  task automatic fill(input int pat);
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++)
        case (pat)
          0:       img[y][x] = 100;
          1:       img[y][x] = x * 10;
          2:       img[y][x] = (y < 3) ? 0 : 255;
          3:       img[y][x] = int'($urandom_range(0, 255));
          default: img[y][x] = 70 - x * 10;
        endcase
  endtask

  task automatic send_pix(input int pix, input int md, input int thr, input bit stall);
    int budget;
    if (stall)
      while ($urandom_range(0, 9) < 3) begin
        in_valid = 1'b0;
        @(posedge clk);
        #1;
      end
    in_valid = 1'b1;
    in_pixel = pix[PW-1:0];
    mode     = md[1:0];
    thresh   = thr[PW+2:0];
    budget   = 0;
    forever begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk);
        #1;
        break;
      end
      @(posedge clk);
      #1;
      budget++;
      if (budget > 1000) begin
        chk("accept_timeout", 0, 1);
        break;
      end
    end
  endtask

  task automatic send_frame(input int md_a, input int md_b, input int sw_idx, input int thr, input bit stall);
    for (int idx = 0; idx < W * H; idx++)
      send_pix(img[idx / W][idx % W], (idx < sw_idx) ? md_a : md_b, thr, stall);
  endtask

  task automatic drain(input int n);
    int cyc = 0;
    in_valid = 1'b0;
    while (got.size() < n && cyc < 500) begin
      @(posedge clk);
      cyc++;
    end
    repeat (5) @(posedge clk);
    #1;
    chk("result_count", got.size(), n);
  endtask

  task automatic check_seq(input int first, input int md, input int thr);
    int i = first;
    for (int cy = 1; cy <= H - 2; cy++)
      for (int cx = 1; cx <= W - 2; cx++) begin
        if (i < got.size()) begin
          chk($sformatf("pix(%0d,%0d)", cx, cy), got[i].pix, sobel_ref(cx, cy, md, thr));
          chk($sformatf("xy_last(%0d,%0d)", cx, cy), got[i].x * 1000 + got[i].y * 10 + got[i].last,
              cx * 1000 + cy * 10 + ((cx == W - 2 && cy == H - 2) ? 1 : 0));
        end
        i++;
      end
  endtask

  vec_t vecs [15];

  initial begin
    int found;
    int val;
    vecs[0]  = '{0, 0, 0,    3, 2, 0};
    vecs[1]  = '{1, 0, 0,    1, 1, 80};
    vecs[2]  = '{1, 1, 0,    4, 3, 0};
    vecs[3]  = '{1, 2, 0,    6, 4, 80};
    vecs[4]  = '{4, 0, 0,    2, 3, -80};
    vecs[5]  = '{4, 2, 0,    5, 1, 80};
    vecs[6]  = '{2, 1, 0,    2, 2, 1020};
    vecs[7]  = '{2, 1, 0,    5, 3, 1020};
    vecs[8]  = '{2, 1, 0,    3, 1, 0};
    vecs[9]  = '{2, 2, 0,    1, 2, 1020};
    vecs[10] = '{2, 2, 0,    6, 4, 0};
    vecs[11] = '{2, 3, 500,  4, 3, 255};
    vecs[12] = '{2, 3, 500,  4, 1, 0};
    vecs[13] = '{2, 3, 1020, 2, 2, 255};
    vecs[14] = '{2, 3, 1021, 2, 2, 0};

    rst = 1'b1; in_valid = 1'b0; in_pixel = '0; mode = 2'b00; thresh = '0;
    #12;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_pixel", int'(out_pixel), 0);
    chk("rst_out_x", int'(out_x), 0);
    chk("rst_out_y", int'(out_y), 0);
    chk("rst_out_last", int'(out_last), 0);
    chk("rst_in_ready", int'(in_ready), 1);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    foreach (vecs[i]) begin
      fill(vecs[i].pat);
      got.delete();
      send_frame(vecs[i].md, vecs[i].md, 0, vecs[i].thr, 1'b0);
      drain(NRES);
      check_seq(0, vecs[i].md, vecs[i].thr);
      found = 0;
      val   = 0;
      foreach (got[j])
        if (got[j].x == vecs[i].cx && got[j].y == vecs[i].cy) begin
          found = 1;
          val   = got[j].pix;
        end
      chk($sformatf("vec%0d_found", i), found, 1);
      chk($sformatf("vec%0d_value", i), val, vecs[i].exp);
      $display("vec %0d pat=%0d mode=%0d thr=%0d (%0d,%0d) -> %0d", i, vecs[i].pat, vecs[i].md,
               vecs[i].thr, vecs[i].cx, vecs[i].cy, val);
    end

    // Random image with input gaps and output back-pressure.
    fill(3);
    got.delete();
    ready_mode = 1;
    send_frame(0, 0, 0, 0, 1'b1);
    drain(NRES);
    ready_mode = 0;
    check_seq(0, 0, 0);
    $display("stall run: %0d results", got.size());

    // Mode switched to 10 at pixel (3,2): frame 1 stays Gx, back-to-back frame 2 is magnitude.
    fill(3);
    got.delete();
    send_frame(0, 2, 2 * W + 3, 0, 1'b0);
    send_frame(2, 2, 0, 0, 1'b0);
    drain(2 * NRES);
    check_seq(0, 0, 0);
    check_seq(NRES, 2, 0);
    if (got.size() > NRES)
      chk("frame2_first_xy", got[NRES].x * 1000 + got[NRES].y, 1001);
    $display("mode switch run: %0d results", got.size());

    // Reset in row 3 while a result is held.
    fill(3);
    got.delete();
    for (int idx = 0; idx < 3 * W + 2; idx++)
      send_pix(img[idx / W][idx % W], 0, 0, 1'b0);
    in_valid = 1'b1;
    in_pixel = img[3][2][PW-1:0];
    @(negedge clk);
    chk("pre_rst_in_ready", int'(in_ready), 1);
    ready_mode = 2;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("pre_rst_held_valid", int'(out_valid), 1);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_valid", int'(out_valid), 0);
    chk("async_rst_in_ready", int'(in_ready), 1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    ready_mode = 0;
    got.delete();
    @(posedge clk);
    #1;
    fill(3);
    send_frame(0, 0, 0, 0, 1'b0);
    drain(NRES);
    check_seq(0, 0, 0);
    if (got.size() > 0)
      chk("post_rst_first_xy", got[0].x * 1000 + got[0].y, 1001);
    $display("post reset run: %0d results", got.size());

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
